// File: rtl/memb_pkg.sv
// Shared types and sizing helpers for the B-matrix column buffer sequencer.
// Imported by memb_ctrl.
package memb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } memb_state_t;

    // Enabled flush cycles needed to drain the deepest skewed column.
    function automatic int flush_len(input int dim);
        return 2 * dim - 1;
    endfunction

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/memb_ctrl.sv
// Load/flush sequencer for the skewed B column buffer: streams one DIM-row
// tile into the buffer, then shifts zeros until every column has drained.
module memb_ctrl
    import memb_pkg::*;
#(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   row_valid,
    output logic                   row_ready,
    input  logic [DIM*BITS_AB-1:0] row_data,
    input  logic                   stall,
    output logic                   memb_en,
    output logic [DIM*BITS_AB-1:0] memb_bin,
    output logic                   compute_en,
    output logic                   busy,
    output logic                   done
);

    localparam int RW = cnt_w(DIM);
    localparam int FW = cnt_w(2 * DIM);

    localparam logic [RW-1:0] ROW_LAST   = RW'(DIM - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(flush_len(DIM) - 1);

    memb_state_t   state_q, state_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;

    logic                   ready_c;
    logic                   en_c;
    logic                   ce_c;
    logic                   done_c;
    logic [DIM*BITS_AB-1:0] bin_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        flush_cnt_d = flush_cnt_q;
        ready_c     = 1'b0;
        en_c        = 1'b0;
        ce_c        = 1'b0;
        done_c      = 1'b0;
        bin_c       = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ready_c = 1'b1;
                // A bubble leaves the buffer frozen so the skew stays aligned.
                if (row_valid) begin
                    en_c  = 1'b1;
                    bin_c = row_data;
                    if (row_cnt_q == ROW_LAST) begin
                        row_cnt_d = '0;
                        state_d   = FLUSH;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                en_c = !stall;
                ce_c = !stall;
                if (!stall) begin
                    if (flush_cnt_q == FLUSH_LAST) begin
                        flush_cnt_d = '0;
                        state_d     = DONE;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Held quiet during reset so the buffer never shifts while it is cleared.
    assign row_ready  = rst_n & ready_c;
    assign memb_en    = rst_n & en_c;
    assign compute_en = rst_n & ce_c;
    assign done       = rst_n & done_c;
    assign busy       = rst_n & (state_q != IDLE);
    assign memb_bin   = rst_n ? bin_c : '0;

endmodule

// File: tb/tb_memb_ctrl.sv
// Self-checking bench for memb_ctrl: expected waveforms are derived from
// the tile timing rules (load window, flush window, done) per stimulus.
module tb_memb_ctrl;

    localparam int BITS = 8;
    localparam int DIM  = 8;
    localparam int W    = BITS * DIM;
    localparam int N    = 64;
    localparam int OW   = W + 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         row_valid = 1'b0;
    logic         row_ready;
    logic [W-1:0] row_data = '0;
    logic         stall = 1'b0;
    logic         memb_en;
    logic [W-1:0] memb_bin;
    logic         compute_en;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;

    bit            vld_a [N];
    bit            stl_a [N];
    bit            st_a  [N];
    bit            rs_a  [N];
    logic [W-1:0]  rowd  [DIM];
    logic [OW-1:0] obs   [N];
    logic [OW-1:0] exp_v [N];
    int            L_m;
    int            F_m;

    always #5 clk = ~clk;

    memb_ctrl #(.BITS_AB(BITS), .DIM(DIM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .stall     (stall),
        .memb_en   (memb_en),
        .memb_bin  (memb_bin),
        .compute_en(compute_en),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [OW-1:0] snap();
        return {row_ready, memb_en, compute_en, done, busy, memb_bin};
    endfunction

    function automatic int count_bit(input int b);
        int n = 0;
        for (int t = 0; t < N; t++) if (obs[t][b]) n++;
        return n;
    endfunction

    function automatic int first_bit(input int b);
        for (int t = 0; t < N; t++) if (obs[t][b]) return t;
        return -1;
    endfunction

    task automatic clear_stim();
        for (int t = 0; t < N; t++) begin
            vld_a[t] = 1'b1;
            stl_a[t] = 1'b0;
            st_a[t]  = 1'b0;
            rs_a[t]  = 1'b0;
        end
        st_a[0] = 1'b1;
    endtask

    task automatic nominal_rows();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                rowd[r][c*BITS +: BITS] = 8'(8 * r + c);
    endtask

    task automatic random_rows();
        for (int r = 0; r < DIM; r++) rowd[r] = {$urandom, $urandom};
    endtask

    // Tile timing from the rules: DIM accepted rows from cycle 1, then
    // 2*DIM-1 unstalled flush cycles, done one cycle later.
    task automatic build_model();
        int nv = 0;
        int nf = 0;
        int idx = 0;
        int rr = N;
        bit ld, acc, fl;
        L_m = N;
        F_m = N;
        for (int t = 1; t < N; t++) begin
            if (L_m == N) begin
                if (vld_a[t]) begin
                    nv++;
                    if (nv == DIM) L_m = t;
                end
            end else if (F_m == N && !stl_a[t]) begin
                nf++;
                if (nf == 2 * DIM - 1) F_m = t;
            end
        end
        for (int t = N - 1; t >= 0; t--) if (rs_a[t]) rr = t;
        for (int t = 0; t < N; t++) begin
            ld  = (t >= 1) && (t <= L_m);
            acc = ld && vld_a[t];
            fl  = (t > L_m) && (t <= F_m) && !stl_a[t];
            exp_v[t] = {ld, acc || fl, fl, t == F_m + 1,
                        (t >= 1) && (t <= F_m + 1),
                        acc ? rowd[idx] : {W{1'b0}}};
            if (acc) idx++;
            if (t >= rr) exp_v[t] = '0;
        end
    endtask

    task automatic run_stim();
        int k = 0;
        for (int t = 0; t < N; t++) begin
            @(posedge clk);
            #1;
            start     = st_a[t];
            row_valid = vld_a[t];
            stall     = stl_a[t];
            rst_n     = !rs_a[t];
            row_data  = (vld_a[t] && k < DIM) ? rowd[k] : {$urandom, $urandom};
            @(negedge clk);
            obs[t] = snap();
            if (row_ready && row_valid && k < DIM) k++;
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        row_valid = 1'b0;
        stall     = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        logic [OW-1:0] o;
        rst_n     = 1'b0;
        start     = 1'b1;
        row_valid = 1'b1;
        row_data  = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = snap();
            n_cmp++;
            if (o !== '0) begin
                n_bad++;
                $display("FAIL reset_hold cyc %0d got %h exp 0", i, o);
            end
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        start     = 1'b0;
        row_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            o = snap();
            n_cmp++;
            if (o !== '0) begin
                n_bad++;
                $display("FAIL reset_release cyc %0d got %h exp 0", i, o);
            end
        end
    endtask

    task automatic test_nominal();
        int ne = 0;
        bit ok = 1'b1;
        int e;
        logic [W-1:0] bh [3*DIM];
        bit           ch [3*DIM];
        logic [BITS-1:0] bout;
        clear_stim();
        nominal_rows();
        build_model();
        run_stim();
        for (int t = 0; t < N; t++) begin
            n_cmp++;
            if (obs[t] !== exp_v[t]) begin
                n_bad++;
                $display("FAIL nominal cyc %0d got %h exp %h", t, obs[t], exp_v[t]);
            end
        end
        n_cmp++;
        if (first_bit(W + 1) !== 24 || count_bit(W + 1) !== 1) begin
            n_bad++;
            $display("FAIL nominal_done got cyc %0d n %0d exp cyc 24 n 1",
                     first_bit(W + 1), count_bit(W + 1));
        end
        n_cmp++;
        if (count_bit(W + 3) !== 23 || count_bit(W + 2) !== 15) begin
            n_bad++;
            $display("FAIL nominal_counts got en %0d ce %0d exp 23 15",
                     count_bit(W + 3), count_bit(W + 2));
        end
        for (int t = 0; t < N; t++) begin
            if (obs[t][W+3]) begin
                if (ne < 3 * DIM) begin
                    bh[ne] = obs[t][W-1:0];
                    ch[ne] = obs[t][W+2];
                end
                ne++;
            end
        end
        // Column buffer model: column c emits the row entered DIM+c enables ago.
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                e = r + DIM + c;
                if (e >= ne || e >= 3 * DIM) begin
                    ok = 1'b0;
                end else begin
                    bout = bh[e-DIM-c][c*BITS +: BITS];
                    if (bout !== 8'(8 * r + c) || !ch[e]) ok = 1'b0;
                end
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL skew_window got bad element exp 8r+c at enable r+8+c");
        end
    endtask

    task automatic test_bubbles();
        clear_stim();
        vld_a[3] = 1'b0;
        vld_a[6] = 1'b0;
        random_rows();
        build_model();
        run_stim();
        for (int t = 0; t < N; t++) begin
            n_cmp++;
            if (obs[t] !== exp_v[t]) begin
                n_bad++;
                $display("FAIL bubbles cyc %0d got %h exp %h", t, obs[t], exp_v[t]);
            end
        end
        n_cmp++;
        if (first_bit(W + 2) !== 11 || first_bit(W + 1) !== 26) begin
            n_bad++;
            $display("FAIL bubbles_timing got flush %0d done %0d exp 11 26",
                     first_bit(W + 2), first_bit(W + 1));
        end
    endtask

    task automatic test_stall();
        clear_stim();
        for (int t = 12; t < 16; t++) stl_a[t] = 1'b1;
        random_rows();
        build_model();
        run_stim();
        for (int t = 0; t < N; t++) begin
            n_cmp++;
            if (obs[t] !== exp_v[t]) begin
                n_bad++;
                $display("FAIL stall cyc %0d got %h exp %h", t, obs[t], exp_v[t]);
            end
        end
        n_cmp++;
        if (first_bit(W + 1) !== 28 || count_bit(W + 2) !== 15) begin
            n_bad++;
            $display("FAIL stall_timing got done %0d ce %0d exp 28 15",
                     first_bit(W + 1), count_bit(W + 2));
        end
    endtask

    task automatic test_start_busy();
        clear_stim();
        st_a[4]  = 1'b1;
        st_a[24] = 1'b1;
        random_rows();
        build_model();
        run_stim();
        for (int t = 0; t < N; t++) begin
            n_cmp++;
            if (obs[t] !== exp_v[t]) begin
                n_bad++;
                $display("FAIL start_busy cyc %0d got %h exp %h", t, obs[t], exp_v[t]);
            end
        end
        n_cmp++;
        if (count_bit(W + 1) !== 1 || count_bit(W) !== 24) begin
            n_bad++;
            $display("FAIL start_busy_once got done %0d busy %0d exp 1 24",
                     count_bit(W + 1), count_bit(W));
        end
    endtask

    task automatic test_reset_flush();
        clear_stim();
        rs_a[14] = 1'b1;
        random_rows();
        build_model();
        run_stim();
        for (int t = 0; t < N; t++) begin
            n_cmp++;
            if (obs[t] !== exp_v[t]) begin
                n_bad++;
                $display("FAIL reset_flush cyc %0d got %h exp %h", t, obs[t], exp_v[t]);
            end
        end
        n_cmp++;
        if (count_bit(W + 1) !== 0 || obs[14][W+3] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flush_quiet got done %0d en14 %b exp 0 0",
                     count_bit(W + 1), obs[14][W+3]);
        end
        clear_stim();
        nominal_rows();
        build_model();
        run_stim();
        n_cmp++;
        if (count_bit(W + 3) !== 23 || first_bit(W + 1) !== 24) begin
            n_bad++;
            $display("FAIL reset_flush_next got en %0d done %0d exp 23 24",
                     count_bit(W + 3), first_bit(W + 1));
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            do begin
                clear_stim();
                for (int t = 1; t < N; t++) begin
                    vld_a[t] = ($urandom_range(3, 0) != 0);
                    stl_a[t] = ($urandom_range(4, 0) == 0);
                end
                random_rows();
                build_model();
            end while (F_m + 2 >= N);
            for (int t = 1; t <= F_m + 1; t++)
                if ($urandom_range(9, 0) == 0) st_a[t] = 1'b1;
            run_stim();
            for (int t = 0; t < N; t++) begin
                n_cmp++;
                if (obs[t] !== exp_v[t]) begin
                    n_bad++;
                    $display("FAIL random it %0d cyc %0d got %h exp %h",
                             it, t, obs[t], exp_v[t]);
                end
            end
            n_cmp++;
            if (count_bit(W + 3) !== 3 * DIM - 1) begin
                n_bad++;
                $display("FAIL random_en it %0d got %0d exp %0d",
                         it, count_bit(W + 3), 3 * DIM - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bubbles();
        test_stall();
        test_start_busy();
        test_reset_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
